// File: rtl/reset_sequencer.sv
// Reset and clock-qualification sequencer: synchronises MMCM lock, stretches reset,
// then releases NUM_STAGES active-high domain resets in order with a fixed gap.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned STRETCH_CYCLES = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked_in,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int unsigned GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STRETCH   = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic                  r_s1;
    logic                  r_locked_s;
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [GAP_W-1:0]      r_gap;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic [LOSS_CNT_W-1:0] r_loss;

    // Released stages always form a contiguous run of zeros from bit 0, so
    // releasing the next stage is a left shift and the last one leaves all zeros.
    logic [NUM_STAGES-1:0] w_rst_next;
    logic                  w_last_stage;

    always_comb begin
        w_rst_next   = r_rst_out << 1;
        w_last_stage = (w_rst_next == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1       <= 1'b0;
            r_locked_s <= 1'b0;
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_rst_out  <= '1;
            r_ready    <= 1'b0;
            r_loss     <= '0;
        end else begin
            r_s1       <= locked_in;
            r_locked_s <= r_s1;

            if (r_state == S_WAIT_LOCK) begin
                r_rst_out <= '1;
                r_ready   <= 1'b0;
                if (r_locked_s) begin
                    r_state <= S_STRETCH;
                    r_cnt   <= '0;
                    r_gap   <= '0;
                end
            end else if (!r_locked_s) begin
                // Lock loss outranks a coincident soft request.
                r_state   <= S_WAIT_LOCK;
                r_cnt     <= '0;
                r_gap     <= '0;
                r_rst_out <= '1;
                r_ready   <= 1'b0;
                if (r_loss != '1) begin
                    r_loss <= r_loss + 1'b1;
                end
            end else if (soft_rst_req) begin
                r_state   <= S_STRETCH;
                r_cnt     <= '0;
                r_gap     <= '0;
                r_rst_out <= '1;
                r_ready   <= 1'b0;
            end else begin
                case (r_state)
                    S_STRETCH: begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt     <= '0;
                            r_gap     <= '0;
                            r_rst_out <= w_rst_next;
                            if (w_last_stage) begin
                                r_state <= S_RUN;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= S_RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (r_gap == GAP_LAST) begin
                            r_gap     <= '0;
                            r_rst_out <= w_rst_next;
                            if (w_last_stage) begin
                                r_state <= S_RUN;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: begin
                        r_rst_out <= '0;
                        r_ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (3/16/4, 3/4/2 with 2-bit loss counter,
// 1/4/16) checked every cycle against a time-since-qualification model plus literals.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    localparam int P_N [3] = '{3, 3, 1};
    localparam int P_SC[3] = '{16, 4, 4};
    localparam int P_SG[3] = '{4, 2, 16};
    localparam int P_W [3] = '{8, 2, 8};

    logic rst_n[3] = '{1'b0, 1'b0, 1'b0};
    logic lk   [3] = '{1'b0, 1'b0, 1'b0};
    logic sr   [3] = '{1'b0, 1'b0, 1'b0};

    logic [2:0] a_ro;  logic a_rdy;  logic [7:0] a_cnt;
    logic [2:0] b_ro;  logic b_rdy;  logic [1:0] b_cnt;
    logic [0:0] c_ro;  logic c_rdy;  logic [7:0] c_cnt;

    reset_sequencer #(.NUM_STAGES(3), .STRETCH_CYCLES(16), .STAGE_GAP(4), .LOSS_CNT_W(8)) u_a (
        .clk(clk), .rst(rst_n[0]), .locked_in(lk[0]), .soft_rst_req(sr[0]),
        .rst_out(a_ro), .ready(a_rdy), .lock_loss_cnt(a_cnt));
    reset_sequencer #(.NUM_STAGES(3), .STRETCH_CYCLES(4), .STAGE_GAP(2), .LOSS_CNT_W(2)) u_b (
        .clk(clk), .rst(rst_n[1]), .locked_in(lk[1]), .soft_rst_req(sr[1]),
        .rst_out(b_ro), .ready(b_rdy), .lock_loss_cnt(b_cnt));
    reset_sequencer #(.NUM_STAGES(1), .STRETCH_CYCLES(4), .STAGE_GAP(16), .LOSS_CNT_W(8)) u_c (
        .clk(clk), .rst(rst_n[2]), .locked_in(lk[2]), .soft_rst_req(sr[2]),
        .rst_out(c_ro), .ready(c_rdy), .lock_loss_cnt(c_cnt));

    logic [7:0] got_ro [3];
    logic       got_rdy[3];
    logic [7:0] got_cnt[3];
    assign got_ro[0]  = {5'b0, a_ro};
    assign got_ro[1]  = {5'b0, b_ro};
    assign got_ro[2]  = {7'b0, c_ro};
    assign got_rdy[0] = a_rdy;
    assign got_rdy[1] = b_rdy;
    assign got_rdy[2] = c_rdy;
    assign got_cnt[0] = a_cnt;
    assign got_cnt[1] = {6'b0, b_cnt};
    assign got_cnt[2] = c_cnt;

    // Model: two-sample lock delay, "active" once qualified, t = edges since the
    // sequence (re)started; stage k is released once t >= SC + k*SG.
    bit m_s1 [3] = '{0, 0, 0};
    bit m_s2 [3] = '{0, 0, 0};
    bit m_act[3] = '{0, 0, 0};
    int m_t  [3] = '{0, 0, 0};
    int m_loss[3] = '{0, 0, 0};

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                m_s1[i] = 0; m_s2[i] = 0; m_act[i] = 0; m_t[i] = 0; m_loss[i] = 0;
            end else begin
                if (m_act[i] && !m_s2[i]) begin
                    m_act[i] = 0;
                    m_t[i]   = 0;
                    if (m_loss[i] < (1 << P_W[i]) - 1) m_loss[i]++;
                end else if (m_act[i] && sr[i]) begin
                    m_t[i] = 0;
                end else if (!m_act[i] && m_s2[i]) begin
                    m_act[i] = 1;
                    m_t[i]   = 0;
                end else if (m_act[i] && m_t[i] < 100000) begin
                    m_t[i]++;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = lk[i];
            end
        end
    end

    function automatic logic [7:0] exp_ro(int i);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < P_N[i]; k++)
            v[k] = !(m_act[i] && m_t[i] >= P_SC[i] + k * P_SG[i]);
        return v;
    endfunction

    function automatic logic exp_rdy(int i);
        return m_act[i] && m_t[i] >= P_SC[i] + (P_N[i] - 1) * P_SG[i];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model rst_out[%0d]", i), 32'(got_ro[i]), 32'(exp_ro(i)));
                chk($sformatf("model ready[%0d]", i), 32'(got_rdy[i]), 32'(exp_rdy(i)));
                chk($sformatf("model loss_cnt[%0d]", i), 32'(got_cnt[i]), 32'(m_loss[i]));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(int target);
        while (cyc < target) step(1);
    endtask

    int e0, ls, s0, r0;

    initial begin
        step(1);
        chk_en = 1'b1;

        // Instance A: power-up
        step(4);
        chk("A reset rst_out", 32'(a_ro), 32'h7);
        chk("A reset ready", 32'(a_rdy), 32'h0);
        chk("A reset loss_cnt", 32'(a_cnt), 32'h0);
        rst_n[0] = 1'b1;
        step(10);
        chk("A wait rst_out", 32'(a_ro), 32'h7);
        lk[0] = 1'b1;
        e0 = cyc + 1;
        at(e0 + 17); chk("A E0+17 rst_out", 32'(a_ro), 32'h7);
        at(e0 + 18); chk("A E0+18 rst_out", 32'(a_ro), 32'h6);
        at(e0 + 21); chk("A E0+21 rst_out", 32'(a_ro), 32'h6);
        at(e0 + 22); chk("A E0+22 rst_out", 32'(a_ro), 32'h4);
        at(e0 + 25); chk("A E0+25 ready", 32'(a_rdy), 32'h0);
        at(e0 + 26);
        chk("A E0+26 rst_out", 32'(a_ro), 32'h0);
        chk("A E0+26 ready", 32'(a_rdy), 32'h1);
        chk("A E0+26 loss_cnt", 32'(a_cnt), 32'h0);

        // Lock loss in RUN, three low samples
        step(5);
        lk[0] = 1'b0;
        ls = cyc + 1;
        at(ls + 1); chk("A loss+1 ready", 32'(a_rdy), 32'h1);
        at(ls + 2);
        chk("A loss+2 rst_out", 32'(a_ro), 32'h7);
        chk("A loss+2 ready", 32'(a_rdy), 32'h0);
        chk("A loss+2 loss_cnt", 32'(a_cnt), 32'h1);
        lk[0] = 1'b1;
        e0 = ls + 3;
        at(e0 + 17); chk("A relock E0+17 rst_out", 32'(a_ro), 32'h7);
        at(e0 + 18); chk("A relock E0+18 rst_out", 32'(a_ro), 32'h6);

        // Soft request while rst_out = 110
        sr[0] = 1'b1;
        step(1);
        sr[0] = 1'b0;
        s0 = cyc;
        chk("A soft rst_out", 32'(a_ro), 32'h7);
        chk("A soft loss_cnt", 32'(a_cnt), 32'h1);
        at(s0 + 15); chk("A soft+15 rst_out", 32'(a_ro), 32'h7);
        at(s0 + 16); chk("A soft+16 rst_out", 32'(a_ro), 32'h6);
        at(s0 + 24); chk("A soft+24 ready", 32'(a_rdy), 32'h1);

        // Soft request on the same edge locked_s first reads 0
        step(3);
        lk[0] = 1'b0;
        ls = cyc + 1;
        at(ls + 1);
        sr[0] = 1'b1;
        at(ls + 2);
        sr[0] = 1'b0;
        chk("A simul rst_out", 32'(a_ro), 32'h7);
        chk("A simul loss_cnt", 32'(a_cnt), 32'h2);
        step(10);
        chk("A simul hold rst_out", 32'(a_ro), 32'h7);
        lk[0] = 1'b1;
        e0 = cyc + 1;
        at(e0 + 18); chk("A simul relock rst_out", 32'(a_ro), 32'h6);
        at(e0 + 26); chk("A simul relock ready", 32'(a_rdy), 32'h1);

        // Synchronous reset in the middle of STRETCH
        step(2);
        sr[0] = 1'b1;
        step(1);
        sr[0] = 1'b0;
        step(2);
        rst_n[0] = 1'b0;
        step(1);
        chk("A midreset rst_out", 32'(a_ro), 32'h7);
        chk("A midreset ready", 32'(a_rdy), 32'h0);
        chk("A midreset loss_cnt", 32'(a_cnt), 32'h0);
        rst_n[0] = 1'b1;
        r0 = cyc + 1;
        at(r0 + 25); chk("A post-reset ready early", 32'(a_rdy), 32'h0);
        at(r0 + 26); chk("A post-reset ready", 32'(a_rdy), 32'h1);

        // Instance B: saturating loss counter
        rst_n[1] = 1'b1;
        lk[1] = 1'b1;
        e0 = cyc + 1;
        at(e0 + 10); chk("B first ready", 32'(b_rdy), 32'h1);
        for (int j = 1; j <= 5; j++) begin
            lk[1] = 1'b0;
            step(3);
            chk($sformatf("B loss %0d cnt", j), 32'(b_cnt), 32'(j < 3 ? j : 3));
            chk($sformatf("B loss %0d rst_out", j), 32'(b_ro), 32'h7);
            lk[1] = 1'b1;
            step(12);
            chk($sformatf("B loss %0d ready", j), 32'(b_rdy), 32'h1);
        end

        // Instance C: single stage
        rst_n[2] = 1'b1;
        step(3);
        lk[2] = 1'b1;
        e0 = cyc + 1;
        at(e0 + 5);
        chk("C E0+5 rst_out", 32'(c_ro), 32'h1);
        chk("C E0+5 ready", 32'(c_rdy), 32'h0);
        at(e0 + 6);
        chk("C E0+6 rst_out", 32'(c_ro), 32'h0);
        chk("C E0+6 ready", 32'(c_rdy), 32'h1);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
